// File: rtl/stopwatch_btn_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_btn_ctrl
//
// Button-conditioning front end for the stopwatch. Two raw push-buttons
// (start/stop and clear) are synchronised, debounced and turned into the run
// level (go) and clear request (clr) consumed by the stopwatch counter.
//
// Parameters:
//   DB_COUNT  consecutive stable clk cycles needed to accept a new button
//             level (must be >= 2).
//   CW        debounce counter width, derived from DB_COUNT.
//
// Ports:
//   clk      in   system clock, the only clock
//   reset    in   synchronous, active-low reset
//   btn_go   in   raw start/stop button (async, active-high, bouncy)
//   btn_clr  in   raw clear button (async, active-high, bouncy)
//   go       out  run level, 1 = counting; toggled by each accepted go press
//   clr      out  clear request; one-cycle pulse per accepted clear press
//   db_go    out  debounced btn_go level
//   db_clr   out  debounced btn_clr level
//
// Build option:
//   CLR_LEVEL_EN  when defined, clr follows db_clr (delayed one cycle) as a
//                 level, and go is held at 0 while db_clr is high.
// -----------------------------------------------------------------------------
module stopwatch_btn_ctrl #(
    parameter int unsigned  DB_COUNT = 2000000,
    localparam int unsigned CW       = $clog2(DB_COUNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_go,
    input  logic btn_clr,
    output logic go,
    output logic clr,
    output logic db_go,
    output logic db_clr
);

    // Button index: 0 = go, 1 = clr.
    localparam int unsigned NumBtn = 2;
    localparam int unsigned IdxGo  = 0;
    localparam int unsigned IdxClr = 1;

    // Counter value at which the last qualifying sample is taken, and the
    // saturation ceiling.
    localparam logic [CW-1:0] CntLast = CW'(DB_COUNT - 2);
    localparam logic [CW-1:0] CntMax  = CW'(DB_COUNT - 1);

    typedef enum logic [1:0] {
        StZero,
        StWait1,
        StOne,
        StWait0
    } db_state_e;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q;
    logic [NumBtn-1:0] sync2_q;

    db_state_e         state_q [NumBtn];
    logic [CW-1:0]     cnt_q   [NumBtn];
    logic [NumBtn-1:0] db_q;
    logic [NumBtn-1:0] tick_q;

    logic go_q;
    logic clr_q;

    assign btn_raw = {btn_clr, btn_go};

    // -------------------------------------------------------------------------
    // Two-flop synchronisers; only the second stage is used downstream.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-button debounce FSM. db and the rise tick are registered alongside
    // the state. Entering a WAIT state counts as the first stable sample, so
    // a level is accepted after DB_COUNT consecutive samples of the new value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NumBtn; i++) begin
                state_q[i] <= StZero;
                cnt_q[i]   <= '0;
            end
            db_q   <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NumBtn; i++) begin
                tick_q[i] <= 1'b0;
                unique case (state_q[i])
                    StZero: begin
                        db_q[i] <= 1'b0;
                        if (sync2_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= StWait1;
                        end
                    end
                    StWait1: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= StZero;
                        end else begin
                            if (cnt_q[i] != CntMax) begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                            if (cnt_q[i] >= CntLast) begin
                                state_q[i] <= StOne;
                                db_q[i]    <= 1'b1;
                                tick_q[i]  <= 1'b1;
                            end
                        end
                    end
                    StOne: begin
                        db_q[i] <= 1'b1;
                        if (!sync2_q[i]) begin
                            cnt_q[i]   <= '0;
                            state_q[i] <= StWait0;
                        end
                    end
                    StWait0: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= StOne;
                        end else begin
                            if (cnt_q[i] != CntMax) begin
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                            end
                            // Release is accepted silently: no tick.
                            if (cnt_q[i] >= CntLast) begin
                                state_q[i] <= StZero;
                                db_q[i]    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q[i] <= StZero;
                        db_q[i]    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // go / clr generation, registered off the debounce ticks. A clear press
    // always wins over a simultaneous go press.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            go_q  <= 1'b0;
            clr_q <= 1'b0;
        end else begin
`ifdef CLR_LEVEL_EN
            clr_q <= db_q[IdxClr];
            if (tick_q[IdxClr] || db_q[IdxClr]) begin
                go_q <= 1'b0;
            end else if (tick_q[IdxGo]) begin
                go_q <= ~go_q;
            end
`else
            clr_q <= tick_q[IdxClr];
            if (tick_q[IdxClr]) begin
                go_q <= 1'b0;
            end else if (tick_q[IdxGo]) begin
                go_q <= ~go_q;
            end
`endif
        end
    end

    assign go     = go_q;
    assign clr    = clr_q;
    assign db_go  = db_q[IdxGo];
    assign db_clr = db_q[IdxClr];

endmodule

// File: doc/stopwatch_btn_ctrl.md
Name: stopwatch_btn_ctrl

Overview:
Button-conditioning front end for the stopwatch; sits directly upstream of the stopwatch counter and drives its go and clr inputs.
- Synchronises and debounces two raw push-buttons (start/stop, clear).
- Start/stop presses toggle a run level (go).
- Clear presses produce a one-cycle clr pulse and stop the watch.

Parameters:
DB_COUNT, 2000000, consecutive stable clk cycles required to accept a new button level (20 ms at 100 MHz); must be >= 2.
CW, $clog2(DB_COUNT+1), debounce counter width; derived, not overridden.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
btn_go  input  1  raw start/stop button, asynchronous, active-high, bouncy.
btn_clr  input  1  raw clear button, asynchronous, active-high, bouncy.
go  output  1  run level to the stopwatch counter; 1 = counting.
clr  output  1  clear request to the stopwatch counter; one-cycle pulse.
db_go  output  1  debounced btn_go level (status/LED).
db_clr  output  1  debounced btn_clr level (status/LED).

Behaviour:
- Reset (reset==0 at a clk edge):
  - go=0, clr=0, db_go=0, db_clr=0.
  - Synchroniser flops cleared, debounce counters cleared, both FSMs in ZERO.
  - Reset overrides all other events in the same cycle.
- Synchronisation: each raw button passes through two flops (s1->s2). Only s2 is used downstream.
- Per-button debounce FSM, identical for both buttons, states ZERO, WAIT1, ONE, WAIT0:
  - ZERO: db=0. If s2==1: counter<=0, go to WAIT1.
  - WAIT1: db=0.
    - If s2==0: return to ZERO.
    - Else counter++. When counter reaches DB_COUNT-1: go to ONE and emit a one-cycle rise tick.
  - ONE: db=1. If s2==0: counter<=0, go to WAIT0.
  - WAIT0: db=1.
    - If s2==1: return to ONE.
    - Else counter++. When counter reaches DB_COUNT-1: go to ZERO. No tick on release.
  - Any glitch shorter than DB_COUNT cycles never changes db.
  - The counter saturates and never wraps.
- Latency: from a clean raw rising edge to db rise, the rise tick, and the go/clr update is 2 + DB_COUNT + 1 cycles. go/clr are registered off the tick.
- go logic, registered:
  - clr tick this cycle: go<=0.
  - Else go-button tick: go<=~go.
  - Else go holds.
- clr logic, registered: clr<=clr tick; high for exactly one cycle per accepted clr press.
- Simultaneous go tick and clr tick in the same cycle: clr wins, so go<=0 and clr<=1.
- Holding either button indefinitely generates exactly one tick. A further tick requires release (full WAIT0 qualification) and a new press.
- Reset mid-debounce discards partial qualification; no tick is emitted after reset is released unless the button re-qualifies from ZERO.

Optional Feature:
Macro CLR_LEVEL_EN.
- Defined: clr is a level equal to registered db_clr (high for as long as the debounced clear button is held, one cycle after db_clr). go is forced to 0, and go toggles are ignored, while db_clr==1.
- Undefined: clr is the one-cycle pulse described above.
- Reset values are unchanged in both builds.

Test Plan:
All scenarios use DB_COUNT=4.
- Reset: hold reset=0 for 3 cycles with both buttons high -> go=0, clr=0, db_go=0, db_clr=0 throughout; after release, go rises only after a full requalification (2+4+1 cycles).
- Clean press: btn_go 0->1 held 20 cycles -> go toggles 0->1 exactly once, 7 cycles after the edge. Release, then press again -> go returns to 0.
- Bounce: btn_go toggles every 2 cycles for 12 cycles, then settles at 1 -> db_go rises once, 4 stable cycles after settling; go toggles exactly once.
- Clear while running: go=1, btn_clr pressed clean -> clr=1 for exactly 1 cycle and go=0 in that same cycle; holding btn_clr 50 cycles gives no further pulse (with CLR_LEVEL_EN: clr stays 1 for the whole hold).
- Simultaneous: both buttons rise on the same edge with go=0 -> clr pulses once, go stays 0.
- Reset mid-debounce: btn_go high for 3 cycles after sync, then reset=0 for 1 cycle with btn_go still high -> no go toggle until 4 further stable cycles; go then becomes 1.
